uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that shares the single UART byte transmitter among N_REQ byte requesters (APB register port, debug console, status streamer, …). It accepts one byte per grant by round-robin, drives the transmitter's enable/data, waits for its sticky frame-complete flag, then clears the transmitter with a reset pulse so it is ready for the next frame. A watchdog aborts frames whose completion flag never arrives.

## Interface
- N_REQ, 4: number of requesters (2..8)
- TIMEOUT, 131072: cycles in SEND before abort; must exceed one frame (10 × 10417 = 104170 cycles)
- CLR_CYCLES, 2: length of tx_rst pulse after each frame (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sched_en  in  1  1 = new grants allowed; 0 = finish current frame, grant nothing new
- req_valid  in  N_REQ  requester i has a byte; held until its req_ready pulse
- req_data  in  8×N_REQ  byte of requester i at bits [8i+7:8i]
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted
- tx_en  out  1  transmitter enable, high for the whole frame
- tx_data  out  8  byte to transmitter, stable from load through end of CLEAR
- tx_rst  out  1  active-high clear of transmitter (counters and done flag)
- tx_done  in  1  transmitter frame-complete flag (sticky until tx_rst)
- busy  out  1  state ≠ IDLE
- grant_id  out  $clog2(N_REQ)  index of requester currently/last served
- frame_done  out  1  one-cycle pulse: frame completed normally
- timeout_err  out  1  one-cycle pulse: frame aborted by watchdog

## Operation
- States: IDLE, SEND, CLEAR. Reset state CLEAR with clear counter 0 and reporting suppressed, so the transmitter is cleared after every reset.
- Reset values: tx_rst=1, busy=1, tx_en=0, tx_data=0, req_ready=0, grant_id=0, frame_done=0, timeout_err=0; rr pointer last=N_REQ-1 (requester 0 first).
- IDLE: if sched_en and any req_valid, pick first valid in order last+1, last+2, … , last (mod N_REQ). At that edge: tx_data<=req_data[i], grant_id<=i, last<=i, req_ready[i]<=1 (one cycle), tx_en<=1, timer<=0, state<=SEND.
- SEND: timer increments each cycle. tx_done=1 sampled → tx_en<=0, tx_rst<=1, state<=CLEAR, mark normal. Else timer==TIMEOUT-1 → same transition, timeout_err pulse, mark aborted.
- CLEAR: tx_rst=1 for exactly CLR_CYCLES cycles, then tx_rst<=0, state<=IDLE; frame_done pulses on that exit edge only if marked normal.
- All outputs registered; no combinational path input→output.
- tx_done while IDLE or CLEAR ignored.
- tx_done and timeout on same edge: done wins, no timeout_err.
- sched_en falling during SEND/CLEAR: current frame completes normally.
- req_valid dropped before req_ready: protocol violation, not checked; only IDLE samples requests.
- rst_n asserted mid-frame: immediate return to reset values (tx_rst=1 aborts transmitter), no frame_done/timeout_err.
- Timer width $clog2(TIMEOUT); clear counter width $clog2(CLR_CYCLES+1).

## Timing
- req_valid sampled at edge k → req_ready and tx_en high in cycle k+1.
- tx_done seen at edge m → tx_en low, tx_rst high from cycle m+1 for CLR_CYCLES cycles; frame_done in last CLEAR cycle+1 edge; state IDLE in cycle m+1+CLR_CYCLES.
- Back-to-back: minimum tx_en low gap between frames = CLR_CYCLES+1 cycles.
- After rst_n release: busy for CLR_CYCLES cycles, first grant possible on next edge.
- Max grant-to-grant latency for a continuously valid requester: N_REQ frames.

## Structure
- Package uart_pkg: state enum (IDLE, SEND, CLEAR), BAUD_DIV=32'h28B0, FRAME_BITS=10, default TIMEOUT derived from them.
- Sub-module uart_rr_pick: combinational round-robin pick (req vector, last pointer → one-hot grant, index, any). Reused by future RX-side arbitration.

## Test plan
- Reset: rst_n low → tx_rst=1, busy=1, others 0; release → tx_rst low after 2 cycles, busy=0.
- Single request: req_valid[2]=1, data 0xA5 → req_ready[2] one pulse next cycle, tx_en=1, tx_data=0xA5, grant_id=2; tx_done after 100 cycles → tx_en=0, tx_rst 2 cycles, frame_done one pulse.
- Round-robin: all four valid continuously → grant order 0,1,2,3,0; each gap between tx_en frames = 3 cycles.
- Timeout (TIMEOUT=50 for test): tx_done never asserted → tx_en drops after 50 cycles, timeout_err pulse, no frame_done, next request served.
- sched_en=0 mid-frame with requests pending → current frame completes with frame_done, no further tx_en until sched_en=1.
- rst_n pulsed during SEND → tx_en=0, tx_rst=1 asynchronously, no frame_done/timeout_err, pointer back to requester 0 first.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and UART frame constants for the TX scheduler
// Contents:
//   sched_state_e   : scheduler FSM states
//   BAUD_DIV        : bit-period divider of the UART transmitter
//   FRAME_BITS      : start + 8 data + stop
//   DEFAULT_TIMEOUT : power of two strictly above one full frame in cycles
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } sched_state_e;

    localparam int BAUD_DIV        = 32'h28B0;
    localparam int FRAME_BITS      = 10;
    localparam int FRAME_CYCLES    = FRAME_BITS * (BAUD_DIV + 1);
    localparam int DEFAULT_TIMEOUT = 1 << $clog2(FRAME_CYCLES + 1);

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester and transmitter handshake bundle
// Signals:
//   req_valid[N_REQ]   : requester i has a byte
//   req_data[8*N_REQ]  : byte of requester i at [8i+7:8i]
//   req_ready[N_REQ]   : one-cycle accept pulse
//   tx_en / tx_data    : transmitter enable and byte
//   tx_rst             : transmitter clear (active high)
//   tx_done            : sticky frame-complete flag from transmitter
// Modports: slave = scheduler side, master = requesters/transmitter side.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic               tx_rst;
    logic               tx_done;

    modport slave (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_en, tx_data, tx_rst
    );

    modport master (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_en, tx_data, tx_rst
    );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
// Ports:
//   req_i  : request vector
//   last_i : index served last; search starts at last_i+1
//   gnt_o  : one-hot grant
//   idx_o  : index of granted requester
//   any_o  : at least one request present
module uart_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);

    localparam int GW = $clog2(N_REQ);

    // Scan from the farthest offset down to last_i+1 so the nearest
    // requester after the pointer is the final (winning) assignment.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req_i[(int'(last_i) + off) % N_REQ]) begin
                gnt_o = N_REQ'(1) << ((int'(last_i) + off) % N_REQ);
                idx_o = GW'((int'(last_i) + off) % N_REQ);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART byte transmitter
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sched_en     : allow new grants
//   bus (slave)  : requester handshake and transmitter control
//   busy         : scheduler not idle
//   grant_id     : requester currently/last served
//   frame_done   : pulse, frame completed normally
//   timeout_err  : pulse, frame aborted by watchdog
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CLR_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sched_en,
    uart_tx_sched_if.slave           bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     frame_done,
    output logic                     timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);

    sched_state_e     state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [GW-1:0]    last_q, last_d;
    logic [GW-1:0]    grant_id_q, grant_id_d;
    logic             normal_q, normal_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_rst_q, tx_rst_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_err_q, timeout_err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;
    logic             grant_now;
    logic             send_end;
    logic             clr_end;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign grant_now = (state_q == IDLE) && sched_en && pick_any;
    // tx_done and watchdog expiry on the same edge both end the frame here;
    // the output logic lets tx_done decide it was a normal completion.
    assign send_end  = (state_q == SEND) && (bus.tx_done || (timer_q == TIMER_LAST));
    assign clr_end   = (state_q == CLEAR) && (clr_cnt_q == CLR_LAST);

    // State register. Reset lands in CLEAR so the transmitter is always
    // cleared after reset; normal_q=0 keeps that exit from pulsing frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_now) state_d = SEND;
            SEND:    if (send_end)  state_d = CLEAR;
            CLEAR:   if (clr_end)   state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // Output / datapath next values (all registered below)
    always_comb begin
        timer_d       = timer_q;
        clr_cnt_d     = clr_cnt_q;
        last_d        = last_q;
        grant_id_d    = grant_id_q;
        normal_d      = normal_q;
        tx_en_d       = tx_en_q;
        tx_rst_d      = tx_rst_q;
        tx_data_d     = tx_data_q;
        req_ready_d   = '0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        busy_d        = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    tx_data_d   = bus.req_data[8*pick_idx +: 8];
                    grant_id_d  = pick_idx;
                    last_d      = pick_idx;
                    req_ready_d = pick_gnt;
                    tx_en_d     = 1'b1;
                    timer_d     = '0;
                end
            end
            SEND: begin
                timer_d = timer_q + TW'(1);
                if (send_end) begin
                    tx_en_d       = 1'b0;
                    tx_rst_d      = 1'b1;
                    clr_cnt_d     = '0;
                    normal_d      = bus.tx_done;
                    timeout_err_d = !bus.tx_done;
                end
            end
            CLEAR: begin
                if (clr_end) begin
                    tx_rst_d     = 1'b0;
                    frame_done_d = normal_q;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            clr_cnt_q     <= '0;
            last_q        <= GW'(N_REQ - 1);
            grant_id_q    <= '0;
            normal_q      <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_rst_q      <= 1'b1;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            busy_q        <= 1'b1;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            clr_cnt_q     <= clr_cnt_d;
            last_q        <= last_d;
            grant_id_q    <= grant_id_d;
            normal_q      <= normal_d;
            tx_en_q       <= tx_en_d;
            tx_rst_q      <= tx_rst_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_rst    = tx_rst_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign frame_done    = frame_done_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int TO  = 50;
    localparam int CLR = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sched_en;
    logic         busy;
    logic [1:0]   grant_id;
    logic         frame_done;
    logic         timeout_err;

    uart_tx_sched_if #(.N_REQ(N)) bus ();

    uart_tx_sched #(
        .N_REQ      (N),
        .TIMEOUT    (TO),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sched_en    (sched_en),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: pending bytes per requester and round-robin pointer.
    logic [N-1:0] pend;
    logic [7:0]   data_m [N];
    int           last_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_expect();
        for (int off = 1; off <= N; off++) begin
            if (pend[(last_m + off) % N]) return (last_m + off) % N;
        end
        return -1;
    endfunction

    task automatic fill(input int i);
        if (!pend[i]) begin
            pend[i]   = 1'b1;
            data_m[i] = 8'($urandom);
        end
    endtask

    task automatic drive();
        bus.req_valid = pend;
        for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = data_m[i];
    endtask

    // Called at the negedge of the last cycle of the previous frame's
    // clear/idle window (or right after reset clear). Runs one complete frame.
    task automatic do_frame(input int done_at, input bit drop_en, input bit chk_gap, input int refill);
        int w, g, hi, exp_hi, rcnt, fdc, tec, fd_pos, te_pos, bad, busy_k;
        logic [7:0] b;
        bit normal;
        if (pend == '0) begin
            fill(int'($urandom_range(N - 1)));
            drive();
        end
        w = rr_expect();
        if (w < 0) begin
            check_eq("has_request", 0, 1);
            return;
        end
        b      = data_m[w];
        normal = (done_at <= TO);
        exp_hi = normal ? done_at : TO;
        g      = CLR + 1;
        @(negedge clk);
        while (!bus.tx_en && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (chk_gap) check_eq("gap", g, CLR + 1);
        check_eq("grant_tx_en", bus.tx_en, 1);
        check_eq("req_ready", bus.req_ready, 32'(1) << w);
        check_eq("grant_id", grant_id, w);
        check_eq("tx_data", bus.tx_data, b);

        last_m  = w;
        pend[w] = 1'b0;
        if (refill == 1 || (refill == 2 && $urandom_range(1) == 1)) fill(w);
        if (refill == 2 && $urandom_range(3) == 0) fill(int'($urandom_range(N - 1)));
        drive();
        if (drop_en) sched_en = 1'b0;

        hi  = 1;
        bad = 0;
        while (hi < 300) begin
            if (hi == done_at) bus.tx_done = 1'b1;
            @(negedge clk);
            if (!bus.tx_en) break;
            hi++;
            if (bus.req_ready != '0 || bus.tx_rst || frame_done || timeout_err || bus.tx_data !== b) bad++;
        end
        check_eq("frame_len", hi, exp_hi);
        check_eq("send_clean", bad, 0);

        rcnt = 0; fdc = 0; tec = 0; fd_pos = -1; te_pos = -1; busy_k = 1;
        for (int k = 0; k <= CLR; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.tx_rst) begin
                rcnt++;
                bus.tx_done = 1'b0;
            end
            if (frame_done)  begin fdc++; fd_pos = k; end
            if (timeout_err) begin tec++; te_pos = k; end
            if (bus.tx_en || bus.tx_data !== b) bad++;
            if (k == CLR) busy_k = int'(busy);
        end
        check_eq("tx_rst_len", rcnt, CLR);
        check_eq("frame_done_cnt", fdc, normal ? 1 : 0);
        check_eq("frame_done_pos", fd_pos, normal ? CLR : -1);
        check_eq("timeout_cnt", tec, normal ? 0 : 1);
        check_eq("timeout_pos", te_pos, normal ? -1 : 0);
        check_eq("clear_clean", bad, 0);
        check_eq("busy_idle", busy_k, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx_rst"}, bus.tx_rst, 1);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_tx_en"}, bus.tx_en, 0);
        check_eq({tag, "_tx_data"}, bus.tx_data, 0);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_grant_id"}, grant_id, 0);
        check_eq({tag, "_pulses"}, {frame_done, timeout_err}, 0);
    endtask

    task automatic release_reset(input string tag);
        rst_n  = 1'b1;
        last_m = N - 1;
        @(negedge clk);
        check_eq({tag, "_clr1_tx_rst"}, bus.tx_rst, 1);
        check_eq({tag, "_clr1_busy"}, busy, 1);
        @(negedge clk);
        check_eq({tag, "_clr2_tx_rst"}, bus.tx_rst, 0);
        check_eq({tag, "_clr2_busy"}, busy, 0);
        check_eq({tag, "_no_frame_done"}, frame_done, 0);
    endtask

    int w0;
    int seen;

    initial begin
        rst_n         = 1'b0;
        sched_en      = 1'b1;
        pend          = '0;
        for (int i = 0; i < N; i++) data_m[i] = 8'h00;
        last_m        = N - 1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_done   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        release_reset("reset");

        // Single request from requester 2
        pend[2]   = 1'b1;
        data_m[2] = 8'hA5;
        drive();
        do_frame(30, 1'b0, 1'b1, 0);

        // All requesters continuously valid: strict rotation, 3-cycle gaps
        for (int i = 0; i < N; i++) fill(i);
        drive();
        for (int f = 0; f < 5; f++) do_frame(int'($urandom_range(40, 1)), 1'b0, 1'b1, 1);

        // Watchdog boundaries: done on the expiry edge wins, one later aborts
        do_frame(TO, 1'b0, 1'b1, 1);
        do_frame(TO + 1, 1'b0, 1'b1, 1);
        do_frame(1000, 1'b0, 1'b1, 2);
        do_frame(1, 1'b0, 1'b1, 2);

        // Randomized traffic
        for (int f = 0; f < 25; f++) do_frame(int'($urandom_range(TO + 10, 1)), 1'b0, 1'b1, 2);

        // sched_en dropped mid-frame with requests pending
        for (int i = 0; i < N; i++) fill(i);
        drive();
        do_frame(20, 1'b1, 1'b1, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_en || bus.req_ready != '0 || busy) seen++;
        end
        check_eq("hold_off", seen, 0);
        sched_en = 1'b1;
        do_frame(15, 1'b0, 1'b0, 2);

        // Reset during SEND: pointer must come back to requester 0
        for (int t = 0; t < 8 && last_m == N - 1; t++) do_frame(10, 1'b0, 1'b1, 1);
        for (int i = 0; i < N; i++) fill(i);
        drive();
        w0 = rr_expect();
        @(negedge clk);
        check_eq("rst_pre_tx_en", bus.tx_en, 1);
        check_eq("rst_pre_grant", grant_id, w0);
        last_m   = w0;
        pend[w0] = 1'b0;
        fill(w0);
        drive();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done || timeout_err || bus.tx_en || !bus.tx_rst) seen++;
        end
        check_eq("midrst_quiet", seen, 0);
        release_reset("midrst");
        do_frame(12, 1'b0, 1'b1, 2);
        check_eq("midrst_first_id", grant_id, 0);
        do_frame(int'($urandom_range(TO + 5, 1)), 1'b0, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
